// File: rtl/mlp_seq_ctrl.sv
// Sequencer for a two-layer binary MLP: walks the layer-1 MAC loops per hidden neuron, then the layer-2 loop, then captures the class bit.
// Optional busy-cycle counter enabled by defining MLP_SEQ_CTRL_CYCCNT_EN; otherwise cyc_cnt is tied to 0.
module mlp_seq_ctrl #(
    parameter int N_IN  = 64,
    parameter int N_HID = 128
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    class_out,
    input  logic                                    bin_class,
    output logic [2:0]                              layer,
    output logic                                    acc_clr,
    output logic                                    g_reg_rst7,
    output logic                                    rf_wen,
    output logic                                    rf_ren,
    output logic [6:0]                              rf_waddr,
    output logic [6:0]                              rf_raddr,
    output logic [$clog2(N_IN)-1:0]                 in_addr,
    output logic [$clog2(N_HID*N_IN+N_HID)-1:0]     w_addr,
    output logic [15:0]                             cyc_cnt
);
    localparam int IW = $clog2(N_IN);
    localparam int WW = $clog2(N_HID*N_IN+N_HID);

    typedef enum logic [3:0] {
        S_IDLE, S_L1_CLR, S_L1_ACC, S_L1_DRAIN, S_L1_WB,
        S_L2_CLR, S_L2_ACC, S_L2_DRAIN, S_END, S_DONE
    } state_t;

    state_t          state_reg, state_next;
    logic [6:0]      n_reg, n_next;
    logic [IW-1:0]   in_addr_reg, in_addr_next;
    logic [WW-1:0]   w_addr_reg, w_addr_next;
    logic            w_first_reg, w_first_next;
    logic [6:0]      rf_waddr_reg, rf_waddr_next;
    logic [6:0]      rf_raddr_reg, rf_raddr_next;
    logic            class_reg, class_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            n_reg        <= '0;
            in_addr_reg  <= '0;
            w_addr_reg   <= '0;
            w_first_reg  <= 1'b0;
            rf_waddr_reg <= '0;
            rf_raddr_reg <= '0;
            class_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            n_reg        <= n_next;
            in_addr_reg  <= in_addr_next;
            w_addr_reg   <= w_addr_next;
            w_first_reg  <= w_first_next;
            rf_waddr_reg <= rf_waddr_next;
            rf_raddr_reg <= rf_raddr_next;
            class_reg    <= class_next;
        end
    end

    // Weights are laid out so every issued address is the previous one plus 1 across
    // both layers; only the first L1_ACC cycle of a run restarts at 0.
    always_comb begin
        state_next    = state_reg;
        n_next        = n_reg;
        in_addr_next  = in_addr_reg;
        w_addr_next   = w_addr_reg;
        w_first_next  = w_first_reg;
        rf_waddr_next = rf_waddr_reg;
        rf_raddr_next = rf_raddr_reg;
        class_next    = class_reg;
        layer         = 3'b000;
        done          = 1'b0;
        acc_clr       = 1'b0;
        g_reg_rst7    = 1'b0;
        rf_wen        = 1'b0;
        rf_ren        = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next   = S_L1_CLR;
                    n_next       = '0;
                    w_first_next = 1'b1;
                end
            end
            S_L1_CLR: begin
                layer        = 3'b001;
                acc_clr      = 1'b1;
                state_next   = S_L1_ACC;
                in_addr_next = '0;
                w_addr_next  = w_first_reg ? '0 : w_addr_reg + WW'(1);
                w_first_next = 1'b0;
            end
            S_L1_ACC: begin
                layer = 3'b001;
                if (in_addr_reg == IW'(N_IN - 1)) begin
                    state_next = S_L1_DRAIN;
                end else begin
                    in_addr_next = in_addr_reg + IW'(1);
                    w_addr_next  = w_addr_reg + WW'(1);
                end
            end
            S_L1_DRAIN: begin
                layer         = 3'b001;
                state_next    = S_L1_WB;
                rf_waddr_next = n_reg;
            end
            S_L1_WB: begin
                layer  = 3'b001;
                rf_wen = 1'b1;
                if (n_reg == 7'(N_HID - 1)) begin
                    state_next = S_L2_CLR;
                end else begin
                    state_next = S_L1_CLR;
                    n_next     = n_reg + 7'd1;
                end
            end
            S_L2_CLR: begin
                layer         = 3'b010;
                g_reg_rst7    = 1'b1;
                state_next    = S_L2_ACC;
                rf_raddr_next = '0;
                w_addr_next   = w_addr_reg + WW'(1);
            end
            S_L2_ACC: begin
                layer  = 3'b010;
                rf_ren = 1'b1;
                if (rf_raddr_reg == 7'(N_HID - 1)) begin
                    state_next = S_L2_DRAIN;
                end else begin
                    rf_raddr_next = rf_raddr_reg + 7'd1;
                    w_addr_next   = w_addr_reg + WW'(1);
                end
            end
            S_L2_DRAIN: begin
                layer      = 3'b010;
                state_next = S_END;
            end
            S_END: begin
                layer      = 3'b100;
                class_next = bin_class;
                state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign busy      = (state_reg != S_IDLE);
    assign class_out = class_reg;
    assign in_addr   = in_addr_reg;
    assign w_addr    = w_addr_reg;
    assign rf_waddr  = rf_waddr_reg;
    assign rf_raddr  = rf_raddr_reg;

`ifdef MLP_SEQ_CTRL_CYCCNT_EN
    logic [15:0] cyc_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_reg <= '0;
        end else if (state_reg == S_IDLE && start) begin
            cyc_reg <= '0;
        end else if (busy && cyc_reg != 16'hFFFF) begin
            cyc_reg <= cyc_reg + 16'd1;
        end
    end

    assign cyc_cnt = cyc_reg;
`else
    assign cyc_cnt = '0;
`endif
endmodule

// File: tb/tb_mlp_seq_ctrl.sv
// Self-checking bench for mlp_seq_ctrl at N_IN=4, N_HID=2: every run is compared cycle by cycle
// against an expected trace built from the layer/neuron loop structure.
module tb_mlp_seq_ctrl;
    localparam int N_IN    = 4;
    localparam int N_HID   = 2;
    localparam int IW      = $clog2(N_IN);
    localparam int WW      = $clog2(N_HID*N_IN+N_HID);
    localparam int RUN_LEN = N_HID*(N_IN+3) + N_HID + 4;
`ifdef MLP_SEQ_CTRL_CYCCNT_EN
    localparam int CYC_EXP = RUN_LEN;
`else
    localparam int CYC_EXP = 0;
`endif

    logic          clk, rst, start, bin_class;
    logic          busy, done, class_out, acc_clr, g_reg_rst7, rf_wen, rf_ren;
    logic [2:0]    layer;
    logic [6:0]    rf_waddr, rf_raddr;
    logic [IW-1:0] in_addr;
    logic [WW-1:0] w_addr;
    logic [15:0]   cyc_cnt;

    mlp_seq_ctrl #(.N_IN(N_IN), .N_HID(N_HID)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .class_out(class_out), .bin_class(bin_class), .layer(layer),
        .acc_clr(acc_clr), .g_reg_rst7(g_reg_rst7), .rf_wen(rf_wen), .rf_ren(rf_ren),
        .rf_waddr(rf_waddr), .rf_raddr(rf_raddr), .in_addr(in_addr), .w_addr(w_addr),
        .cyc_cnt(cyc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One entry per busy cycle; -1 in an address field means "not issuing, don't care".
    typedef struct {
        logic [8:0] ctl;   // {busy, done, layer, acc_clr, g_reg_rst7, rf_wen, rf_ren}
        int in_a;
        int w_a;
        int wa;
        int ra;
        bit is_end;
    } exp_t;

    exp_t trace[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic cls_model = 1'b0;

    function automatic void push(logic [2:0] ly, bit dn, bit clr, bit g7, bit wen, bit ren,
                                 int in_a, int w_a, int wa, int ra, bit is_end);
        exp_t e;
        e.ctl    = {1'b1, dn, ly, clr, g7, wen, ren};
        e.in_a   = in_a;
        e.w_a    = w_a;
        e.wa     = wa;
        e.ra     = ra;
        e.is_end = is_end;
        trace.push_back(e);
    endfunction

    function automatic void build_trace();
        for (int n = 0; n < N_HID; n++) begin
            push(3'b001, 0, 1, 0, 0, 0, -1, -1, -1, -1, 0);
            for (int i = 0; i < N_IN; i++)
                push(3'b001, 0, 0, 0, 0, 0, i, n*N_IN + i, -1, -1, 0);
            push(3'b001, 0, 0, 0, 0, 0, -1, -1, -1, -1, 0);
            push(3'b001, 0, 0, 0, 1, 0, -1, -1, n, -1, 0);
        end
        push(3'b010, 0, 0, 1, 0, 0, -1, -1, -1, -1, 0);
        for (int j = 0; j < N_HID; j++)
            push(3'b010, 0, 0, 0, 0, 1, -1, N_HID*N_IN + j, -1, j, 0);
        push(3'b010, 0, 0, 0, 0, 0, -1, -1, -1, -1, 0);
        push(3'b100, 0, 0, 0, 0, 0, -1, -1, -1, -1, 1);
        push(3'b000, 1, 0, 0, 0, 0, -1, -1, -1, -1, 0);
    endfunction

    task automatic check_all_zero(input string tag);
        n_checks++;
        if ({busy, done, layer, acc_clr, g_reg_rst7, rf_wen, rf_ren, rf_waddr, rf_raddr,
             in_addr, w_addr, class_out, cyc_cnt} !== '0)
            $display("FAIL %s: outputs not all zero busy=%b done=%b layer=%b waddr=%0d raddr=%0d in=%0d w=%0d cls=%b cyc=%0d",
                     tag, busy, done, layer, rf_waddr, rf_raddr, in_addr, w_addr, class_out, cyc_cnt);
        else
            n_pass++;
    endtask

    // Called just after a negedge with the DUT idle. force_cls<0 draws bin_class at random.
    // abort_at>=0 asserts rst right after checking that cycle and returns.
    task automatic run(input string name, input bit keep_start, input int force_cls, input int abort_at);
        exp_t e;
        start = 1'b1;
        for (int k = 0; k < RUN_LEN; k++) begin
            @(negedge clk);
            e = trace[k];
            n_checks++;
            if ({busy, done, layer, acc_clr, g_reg_rst7, rf_wen, rf_ren} !== e.ctl)
                $display("FAIL %s ctl cyc=%0d got=%b exp=%b", name, k+1,
                         {busy, done, layer, acc_clr, g_reg_rst7, rf_wen, rf_ren}, e.ctl);
            else n_pass++;
            if (e.in_a >= 0) begin
                n_checks++;
                if (int'(in_addr) !== e.in_a) $display("FAIL %s in_addr cyc=%0d got=%0d exp=%0d", name, k+1, in_addr, e.in_a);
                else n_pass++;
            end
            if (e.w_a >= 0) begin
                n_checks++;
                if (int'(w_addr) !== e.w_a) $display("FAIL %s w_addr cyc=%0d got=%0d exp=%0d", name, k+1, w_addr, e.w_a);
                else n_pass++;
            end
            if (e.wa >= 0) begin
                n_checks++;
                if (int'(rf_waddr) !== e.wa) $display("FAIL %s rf_waddr cyc=%0d got=%0d exp=%0d", name, k+1, rf_waddr, e.wa);
                else n_pass++;
            end
            if (e.ra >= 0) begin
                n_checks++;
                if (int'(rf_raddr) !== e.ra) $display("FAIL %s rf_raddr cyc=%0d got=%0d exp=%0d", name, k+1, rf_raddr, e.ra);
                else n_pass++;
            end
            n_checks++;
            if (class_out !== cls_model) $display("FAIL %s class_out cyc=%0d got=%b exp=%b", name, k+1, class_out, cls_model);
            else n_pass++;
            if (k == 0) begin
                n_checks++;
                if (cyc_cnt !== 16'd0) $display("FAIL %s cyc_cnt_clear got=%0d exp=0", name, cyc_cnt);
                else n_pass++;
            end
            if (abort_at == k) begin
                rst = 1'b1;
                #1;
                check_all_zero({name, " async_rst"});
                cls_model = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                $display("run %s aborted by reset at cycle %0d", name, k+1);
                return;
            end
            bin_class = (e.is_end && force_cls >= 0) ? force_cls[0] : 1'($urandom);
            if (e.is_end) cls_model = bin_class;
            if (!keep_start) start = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if ({busy, done, layer} !== 5'b0) $display("FAIL %s idle_after got busy=%b done=%b layer=%b exp 0", name, busy, done, layer);
        else n_pass++;
        n_checks++;
        if (int'(cyc_cnt) !== CYC_EXP) $display("FAIL %s cyc_cnt got=%0d exp=%0d", name, cyc_cnt, CYC_EXP);
        else n_pass++;
        n_checks++;
        if (class_out !== cls_model) $display("FAIL %s class_hold got=%b exp=%b", name, class_out, cls_model);
        else n_pass++;
        $display("run %s done class_out=%b cyc_cnt=%0d", name, class_out, cyc_cnt);
    endtask

    task automatic idle_gap(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            bin_class = 1'($urandom);
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || class_out !== cls_model)
                $display("FAIL idle_gap got busy=%b class_out=%b exp busy=0 class_out=%b", busy, class_out, cls_model);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        start = 1'b0;
        rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_single_run();
        run("single", 1'b0, -1, -1);
    endtask

    task automatic test_class_hold();
        run("class1", 1'b0, 1, -1);
        idle_gap(3);
        run("class0", 1'b0, 0, -1);
        idle_gap(2);
    endtask

    task automatic test_mid_run_reset();
        run("class1_pre", 1'b0, 1, -1);
        run("abort_l2acc", 1'b0, -1, N_HID*(N_IN+3) + 1);
        run("after_abort", 1'b0, -1, -1);
    endtask

    task automatic test_back_to_back();
        run("b2b_a", 1'b1, -1, -1);
        run("b2b_b", 1'b1, -1, -1);
        start = 1'b0;
        idle_gap(2);
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 4; r++) begin
            idle_gap($urandom_range(0, 4));
            run("random", 1'($urandom), -1, -1);
            start = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        bin_class = 1'b0;
        build_trace();
        @(negedge clk);
        test_reset();
        test_single_run();
        test_class_hold();
        test_mid_run_reset();
        test_back_to_back();
        test_random_runs();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
